// File: rtl/seg_scan_display.sv
// Four-digit multiplexed seven-segment scanner: captures hex data on load,
// swaps it in only at frame boundaries, and blanks anodes for one cycle per digit change.
module seg_scan_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic           DP_DARK  = SEG_ACTIVE_LOW;
    localparam logic [3:0]     AN_OFF   = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] cnt_div;
    logic [1:0]    idx;
    logic          tick_d;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend_lz;
    logic [15:0]   act_val;
    logic [3:0]    act_dp;
    logic          act_lz;

    logic          tick;
    logic          boundary;
    logic [1:0]    idx_next;
    logic [15:0]   nxt_val;
    logic [3:0]    nxt_dp;
    logic          nxt_lz;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_lit;
    logic [6:0]    seg_drive;
    logic          dp_drive;
    logic [3:0]    an_onehot;
    logic [3:0]    an_drive;

    // Segment pattern for one hex nibble, active-high, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0111111;
            4'h1:    hex7 = 7'b0000110;
            4'h2:    hex7 = 7'b1011011;
            4'h3:    hex7 = 7'b1001111;
            4'h4:    hex7 = 7'b1100110;
            4'h5:    hex7 = 7'b1101101;
            4'h6:    hex7 = 7'b1111101;
            4'h7:    hex7 = 7'b0000111;
            4'h8:    hex7 = 7'b1111111;
            4'h9:    hex7 = 7'b1101111;
            4'hA:    hex7 = 7'b1110111;
            4'hB:    hex7 = 7'b1111100;
            4'hC:    hex7 = 7'b0111001;
            4'hD:    hex7 = 7'b1011110;
            4'hE:    hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    // The decode for the incoming digit must see the data the active register
    // is about to take, so a boundary-coincident load shows up in digit 0.
    always_comb begin
        tick      = (cnt_div == DIV_LAST);
        boundary  = tick && (idx == 2'd3);
        idx_next  = idx + 2'd1;
        nxt_val   = act_val;
        nxt_dp    = act_dp;
        nxt_lz    = act_lz;
        if (boundary) begin
            nxt_val = load ? value    : pend_val;
            nxt_dp  = load ? dp_in    : pend_dp;
            nxt_lz  = load ? blank_lz : pend_lz;
        end
        nibble = nxt_val[{idx_next, 2'b00} +: 4];
        case (idx_next)
            2'd3:    blank = nxt_lz && (nxt_val[15:12] == 4'h0);
            2'd2:    blank = nxt_lz && (nxt_val[15:8]  == 8'h00);
            2'd1:    blank = nxt_lz && (nxt_val[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        seg_lit   = blank ? 7'h00 : hex7(nibble);
        seg_drive = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp_drive  = SEG_ACTIVE_LOW ? ~nxt_dp[idx_next] : nxt_dp[idx_next];
        an_onehot = 4'b0001 << idx;
        an_drive  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
    end

    // Anodes go dark on the tick edge while segments change, and the new digit
    // is enabled one edge later; tick_d marks that second edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_div  <= '0;
            idx      <= 2'd3;
            tick_d   <= 1'b0;
            pend_val <= 16'h0000;
            pend_dp  <= 4'h0;
            pend_lz  <= 1'b0;
            act_val  <= 16'h0000;
            act_dp   <= 4'h0;
            act_lz   <= 1'b0;
            seg      <= SEG_DARK;
            dp       <= DP_DARK;
            an       <= AN_OFF;
            frame    <= 1'b0;
        end else begin
            cnt_div <= tick ? '0 : cnt_div + CW'(1);
            tick_d  <= tick;
            frame   <= boundary;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_lz  <= blank_lz;
            end
            if (tick) begin
                idx     <= idx_next;
                act_val <= nxt_val;
                act_dp  <= nxt_dp;
                act_lz  <= nxt_lz;
                seg     <= seg_drive;
                dp      <= dp_drive;
                an      <= AN_OFF;
            end else if (tick_d) begin
                an <= an_drive;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized scoreboard bench for seg_scan_display: the stimulus side predicts each
// frame's four digits from the last load at or before its boundary; a monitor checks lit digits.
module tb_seg_scan_display;

    localparam int D = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam logic [6:0] HEX [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          have_cur;
    bit          mon_en;
    logic [3:0]  prev_an;
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_lz;

    always #5 clk = ~clk;

    seg_scan_display #(
        .SCAN_DIV(D),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value(value),
        .dp_in(dp_in),
        .load(load),
        .blank_lz(blank_lz),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame(frame)
    );

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void check_reset_state();
        checkOutput("rst_an", 32'(an), 32'h0F);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_dp", 32'(dp), 32'h1);
        checkOutput("rst_frame", 32'(frame), 32'h0);
    endfunction

    // Expected digits for one frame, straight from the display rules.
    function automatic void push_frame();
        exp_t       e;
        logic [3:0] nib;
        bit         blk;
        for (int i = 0; i < 4; i++) begin
            nib   = 4'(m_val >> (4 * i));
            blk   = m_lz && (i > 0) && ((m_val >> (4 * i)) == 16'h0000);
            e.an  = ~(4'b0001 << i);
            e.seg = blk ? 7'h7F : ~HEX[nib];
            e.dp  = ~m_dp[i];
            exp_q.push_back(e);
        end
    endfunction

    task automatic step_edge(input bit exp_frame);
        @(posedge clk);
        #1;
        checkOutput("frame", 32'(frame), 32'(exp_frame));
    endtask

    task automatic idle_inputs();
        load     = 1'b0;
        value    = 16'($urandom);
        dp_in    = 4'($urandom);
        blank_lz = 1'($urandom);
    endtask

    // Runs one interval ending on a boundary edge with up to two loads; off2 wins on a tie.
    task automatic applyStimulus(input int len,
                                 input int off1, input logic [15:0] v1, input logic [3:0] d1, input logic l1,
                                 input int off2, input logic [15:0] v2, input logic [3:0] d2, input logic l2);
        for (int o = 1; o <= len; o++) begin
            if (o == off2) begin
                load = 1'b1; value = v2; dp_in = d2; blank_lz = l2;
            end else if (o == off1) begin
                load = 1'b1; value = v1; dp_in = d1; blank_lz = l1;
            end else begin
                idle_inputs();
            end
            step_edge(o == len);
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
                m_lz  = blank_lz;
            end
        end
        idle_inputs();
        push_frame();
    endtask

    task automatic random_interval(input int len);
        applyStimulus(len,
                      int'($urandom_range(0, len)), 16'($urandom), 4'($urandom), 1'($urandom),
                      int'($urandom_range(0, len)), 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    // Each newly lit digit pops one expectation; every lit cycle is compared against it.
    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(~an) == 1) begin
                if (an != prev_an) begin
                    checkOutput("gap_before_digit", 32'(prev_an), 32'h0F);
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        have_cur = 1'b0;
                        $display("[TB] FAIL underflow actual=an_%0h required=no_digit", an);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    checkOutput("an", 32'(an), 32'(cur.an));
                    checkOutput("seg", 32'(seg), 32'(cur.seg));
                    checkOutput("dp", 32'(dp), 32'(cur.dp));
                end
            end else begin
                checkOutput("an_off", 32'(an), 32'h0F);
            end
            prev_an = an;
        end
    end

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        m_val    = 16'h0000;
        m_dp     = 4'h0;
        m_lz     = 1'b0;
        have_cur = 1'b0;
        mon_en   = 1'b0;
        prev_an  = 4'hF;

        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_state();
        end
        mon_en = 1'b1;
        rst_n  = 1'b1;

        applyStimulus(D,     1,     16'h12AF, 4'h0,    1'b0, 0,     16'h0, 4'h0, 1'b0);
        applyStimulus(4 * D, D + 2, 16'h0000, 4'h0,    1'b0, 0,     16'h0, 4'h0, 1'b0);
        applyStimulus(4 * D, 3,     16'h0050, 4'h0,    1'b1, 0,     16'h0, 4'h0, 1'b0);
        applyStimulus(4 * D, 5,     16'h0000, 4'h0,    1'b1, 0,     16'h0, 4'h0, 1'b0);
        applyStimulus(4 * D, 3,     16'h1234, 4'hF,    1'b0, 4 * D, 16'h8888, 4'h0, 1'b0);
        applyStimulus(4 * D, 2,     16'h5A3C, 4'b0100, 1'b0, 0,     16'h0, 4'h0, 1'b0);
        applyStimulus(4 * D, 0,     16'h0,    4'h0,    1'b0, 0,     16'h0, 4'h0, 1'b0);
        repeat (30) random_interval(4 * D);

        // Reset while digit 1 of the current frame is lit.
        for (int o = 1; o <= D + 1; o++) begin
            idle_inputs();
            step_edge(1'b0);
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_state();
        end
        exp_q.delete();
        have_cur = 1'b0;
        m_val    = 16'h0000;
        m_dp     = 4'h0;
        m_lz     = 1'b0;
        rst_n    = 1'b1;

        applyStimulus(D, 0, 16'h0, 4'h0, 1'b0, 0, 16'h0, 4'h0, 1'b0);
        repeat (4) random_interval(4 * D);

        for (int o = 1; o <= 3 * D + 2; o++) begin
            idle_inputs();
            step_edge(1'b0);
        end
        mon_en = 1'b0;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Four-digit multiplexed seven-segment display driver for the board's LED/segment outputs. It captures a 16-bit value (four hex nibbles) plus decimal points on a load strobe. It scans the digits at a divided rate, decodes each nibble to hex segments with optional leading-zero blanking, and applies new data only at frame boundaries so a frame is never torn. It is the display-side consumer for the lab counters, which drive `value`/`load` from the system clock domain.

## Interface

- `SCAN_DIV`, default 50000: clock cycles per digit slot (50 MHz → 1 kHz digit rate); legal range ≥ 2.
- `SEG_ACTIVE_LOW`, default 1: 1 = `seg`/`dp` driven low to light; 0 = high to light.
- `AN_ACTIVE_LOW`, default 1: 1 = `an` bit low enables digit; 0 = high enables.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `value`  in  16  display data; `[3:0]` = digit 0 (rightmost) … `[15:12]` = digit 3.
- `dp_in`  in  4  decimal point per digit; bit i = digit i.
- `load`  in  1  capture strobe; `value`/`dp_in` sampled on any edge where high.
- `blank_lz`  in  1  leading-zero blanking enable.
- `seg`  out  7  segments; `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1  decimal point segment.
- `an`  out  4  digit enables; bit i = digit i.
- `frame`  out  1  one-cycle pulse at each frame start.

## Operation

- Divider `cnt_div` counts 0..SCAN_DIV-1 and wraps to 0. A tick is the cycle where `cnt_div == SCAN_DIV-1`.
- Digit index `idx` advances by 1 on each tick edge, wrapping 3→0. Wrap 3→0 is the frame boundary.
- Pending register (`pend_val`, `pend_dp`, `pend_lz`) loads `value`, `dp_in`, `blank_lz` on every edge with `load` high.
- Active register loads at the frame-boundary edge:
  - `load` high in that cycle: active register takes the live inputs.
  - `load` low: active register takes the pending register.
  - Data loaded mid-frame never affects the remaining digits of the current frame.
- Hex decode, active-high form, order g..a: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. Output is inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking, active only if the active `blank_lz`=1:
  - Digit i (i = 3..1) is blanked when its nibble and all more-significant nibbles are 0.
  - Digit 0 is never blanked.
  - A blanked digit has all segments dark. `dp` still follows its `dp_in` bit.
- Deghosting sequence per tick:
  - Tick edge: `an` all disabled, `seg`/`dp` load the decode of the new digit.
  - Next edge: `an` enables the one-hot new digit.
  - Each digit is therefore lit SCAN_DIV-1 of SCAN_DIV cycles.
- All outputs are registered.

## Timing

- Reset (`rst_n` low at an edge), takes effect at that edge, including mid-scan:
  - `cnt_div`=0, `idx`=3, pending and active registers = 0.
  - `an` all disabled, `seg`/`dp` dark (7'h7F / 1 for active-low).
  - `frame`=0.
- After release, the first tick edge is the SCAN_DIV-th edge. It moves `idx` 3→0, is a frame boundary, and pulses `frame`. Digit 0 lights on the following edge.
- `frame` is high for exactly the one cycle after each boundary edge. Period is 4·SCAN_DIV cycles.
- Load-to-display latency: from the next frame boundary, worst case 4·SCAN_DIV+1 cycles. When `load` coincides with the boundary, the new data is visible in that frame.
- Back-to-back loads within one frame: the last one wins.
- `value`/`dp_in`/`blank_lz` are ignored when `load` is low.

## Test plan

- Reset mid-scan: SCAN_DIV=4, hold `rst_n` low 3 cycles while digit 1 is lit → `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame`=0. After release, `frame` pulses after the 4th edge, then digit 0 lights with `an`=4'b1110.
- Basic scan: SCAN_DIV=4, load 16'h12AF, `dp_in`=0, `blank_lz`=0. Next frame shows:
  - `an`=1110, `seg`=7'b0001110
  - `an`=1101, `seg`=7'b0001000
  - `an`=1011, `seg`=7'b0100100
  - `an`=0111, `seg`=7'b1111001
  - One all-off `an` cycle precedes each digit.
- Mid-frame load: with 16'h12AF showing, load 16'h0000 while digit 1 is lit → digits 2 and 3 still show 2 and 1. All digits show 7'b1000000 from the next frame.
- Leading-zero blanking: load 16'h0050 with `blank_lz`=1 → digits 3 and 2 give `seg`=7'h7F, digit 1 = 7'b0010010, digit 0 = 7'b1000000. Load 16'h0000 → only digit 0 is lit.
- Boundary-coincident load: assert `load` with 16'h8888 in the boundary cycle → that same frame shows 7'b0000000 on all digits.
- Decimal point: `dp_in`=4'b0100 → `dp`=0 only while `an`=4'b1011, otherwise 1.
